// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone memory responder.
// The random-stall option is enabled by defining WB_RESP_RANDSTALL_EN.
package wb_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_resp_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic wb_resp_in_range(
        input logic [31:0] adr,
        input logic [31:0] base,
        input int          shift
    );
        return (adr >> shift) == (base >> shift);
    endfunction

endpackage

// File: rtl/wb_bus_t.sv
// Classic single-beat Wishbone bus bundle with master and slave views.
interface wb_bus_t #(
    parameter int TAGSIZE = 1
);
    logic               cyc;
    logic               stb;
    logic               we;
    logic [31:0]        adr;
    logic [3:0]         sel;
    logic [31:0]        dat_ms;
    logic [31:0]        dat_sm;
    logic               ack;
    logic               err;
    logic [TAGSIZE-1:0] tag;

    modport master (output cyc, stb, we, adr, sel, dat_ms, tag,
                    input  dat_sm, ack, err);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, tag,
                    output dat_sm, ack, err);
endinterface

// File: rtl/wb_resp_lfsr.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
module wb_resp_lfsr
    import wb_resp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        fb_s;

    assign fb_s = ^(state_q & LFSR_TAPS);

    // Shift register state, reseeded on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LFSR_SEED;
        end else if (step_i) begin
            state_q <= {state_q[14:0], fb_s};
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone slave memory with programmable wait states and out-of-window err.
// Defining WB_RESP_RANDSTALL_EN adds 0..3 LFSR-chosen extra wait cycles.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int          TAGSIZE     = 1,
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic   clk_i,
    input  logic   rst_i,
    wb_bus_t.slave wb_bus
);

    localparam int IW    = $clog2(DEPTH);
    localparam int SHIFT = IW + 2;

    wb_resp_state_e state_q;
    logic [4:0]     cnt_q;
    logic [IW-1:0]  idx_q;
    logic           in_range_q;
    logic           we_q;
    logic [3:0]     sel_q;
    logic [31:0]    wdat_q;
    logic           ack_q;
    logic           err_q;
    logic [31:0]    dat_q;
    logic [31:0]    mem_q [DEPTH];

    logic               req_s;
    logic [4:0]         eff_wait_s;
    logic [TAGSIZE-1:0] unused_tag_s;
    logic               unused_adr_s;

    assign req_s        = wb_bus.cyc & wb_bus.stb;
    assign unused_tag_s = wb_bus.tag;
    assign unused_adr_s = ^wb_bus.adr[1:0];

`ifdef WB_RESP_RANDSTALL_EN
    logic [15:0] lfsr_s;
    logic        step_s;
    logic        unused_lfsr_s;

    assign step_s        = (state_q == ST_IDLE) && req_s;
    assign unused_lfsr_s = ^lfsr_s[15:2];

    wb_resp_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .step_i  (step_s),
        .state_o (lfsr_s)
    );
`endif

    // Effective wait count for the request being accepted
    always_comb begin
        eff_wait_s = 5'(WAIT_CYCLES);
`ifdef WB_RESP_RANDSTALL_EN
        eff_wait_s = 5'(WAIT_CYCLES) + {3'b000, lfsr_s[1:0]};
`endif
    end

    // Request capture, only while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            in_range_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            wdat_q     <= 32'h0;
        end else if ((state_q == ST_IDLE) && req_s) begin
            idx_q      <= wb_bus.adr[SHIFT-1:2];
            in_range_q <= wb_resp_in_range(wb_bus.adr, BASE_ADDR, SHIFT);
            we_q       <= wb_bus.we;
            sel_q      <= wb_bus.sel;
            wdat_q     <= wb_bus.dat_ms;
        end
    end

    // Control FSM with registered single-cycle ack/err/data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'h0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        if (eff_wait_s != 5'd0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= eff_wait_s;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    // Dropping cyc abandons the access before anything commits.
                    if (!wb_bus.cyc) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack_q   <= in_range_q;
                    err_q   <= ~in_range_q;
                    if (in_range_q && !we_q) begin
                        dat_q <= mem_q[idx_q];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    // Byte-lane commit on the response edge
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == ST_RESP) && in_range_q && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
                end
            end
        end
    end

    assign wb_bus.ack    = ack_q;
    assign wb_bus.err    = err_q;
    assign wb_bus.dat_sm = dat_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench: three responders (0, 3 and 4 wait states) against a memory model.
module tb_wb_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WAITS [3] = '{0, 3, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_cyc = 1'b0, drv_stb = 1'b0, drv_we = 1'b0;
    logic [31:0] drv_adr = 32'h0, drv_dat = 32'h0;
    logic [3:0]  drv_sel = 4'h0;
    int          sel_dut = 0;
    int          cyc_cnt = 0;
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;

    logic [2:0]  ack_v, err_v;
    logic [31:0] dat_v [3];

    // Reference model state
    logic [31:0] mem_m [3][256];
    bit          pend [3];
    bit          pend_err [3];
    bit          pend_rd [3];
    int          pend_cyc [3];
    logic [31:0] pend_dat [3];
    logic [15:0] lfsr_m [3];

    wb_bus_t #(.TAGSIZE(1)) bus0 ();
    wb_bus_t #(.TAGSIZE(1)) bus1 ();
    wb_bus_t #(.TAGSIZE(1)) bus2 ();

    assign bus0.cyc = drv_cyc && (sel_dut == 0);
    assign bus1.cyc = drv_cyc && (sel_dut == 1);
    assign bus2.cyc = drv_cyc && (sel_dut == 2);
    assign {bus0.stb, bus1.stb, bus2.stb} = {3{drv_stb}};
    assign {bus0.we, bus1.we, bus2.we} = {3{drv_we}};
    assign {bus0.adr, bus1.adr, bus2.adr} = {3{drv_adr}};
    assign {bus0.sel, bus1.sel, bus2.sel} = {3{drv_sel}};
    assign {bus0.dat_ms, bus1.dat_ms, bus2.dat_ms} = {3{drv_dat}};
    assign {bus0.tag, bus1.tag, bus2.tag} = 3'b000;
    assign ack_v = {bus2.ack, bus1.ack, bus0.ack};
    assign err_v = {bus2.err, bus1.err, bus0.err};
    assign dat_v[0] = bus0.dat_sm;
    assign dat_v[1] = bus1.dat_sm;
    assign dat_v[2] = bus2.dat_sm;

    wb_mem_responder #(.TAGSIZE(1), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_CYCLES(0))
        u_dut0 (.clk_i(clk), .rst_i(rst), .wb_bus(bus0));
    wb_mem_responder #(.TAGSIZE(1), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_CYCLES(3))
        u_dut1 (.clk_i(clk), .rst_i(rst), .wb_bus(bus1));
    wb_mem_responder #(.TAGSIZE(1), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_CYCLES(4))
        u_dut2 (.clk_i(clk), .rst_i(rst), .wb_bus(bus2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Every cycle: outputs must match what the model scheduled for that cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic        ea, ee, dat_bad;
                logic [31:0] ed;
                ea = pend[k] && (cyc_cnt == pend_cyc[k]) && !pend_err[k];
                ee = pend[k] && (cyc_cnt == pend_cyc[k]) && pend_err[k];
                ed = (ea && pend_rd[k]) ? pend_dat[k] : 32'h0;
                dat_bad = (ea && !pend_rd[k]) ? 1'b0 : (dat_v[k] !== ed);
                checks++;
                if (ack_v[k] !== ea || err_v[k] !== ee || dat_bad) begin
                    errors++;
                    $display("FAIL bus_out dut%0d cycle %0d: ack/err/dat=%b/%b/%h expected %b/%b/%h",
                             k, cyc_cnt, ack_v[k], err_v[k], dat_v[k], ea, ee, ed);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reseed();
        for (int k = 0; k < 3; k++) lfsr_m[k] = 16'hACE1;
    endtask

    // One single-beat access; abort_at>0 ends it after that many cycles via cyc drop or reset
    task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, input bit abort_rst,
                        output logic [31:0] rd, output int lat);
        int n, ew, widx;
        bit inr, seen;
        @(negedge clk);
        sel_dut = k; drv_we = w; drv_adr = a; drv_sel = s; drv_dat = d;
        drv_cyc = 1'b1; drv_stb = 1'b1;
        @(posedge clk); #1;
        n  = cyc_cnt;
        ew = WAITS[k];
`ifdef WB_RESP_RANDSTALL_EN
        ew = ew + int'(lfsr_m[k][1:0]);
        lfsr_m[k] = lfsr_next(lfsr_m[k]);
`endif
        inr  = (a >= BASE) && (a < BASE + 32'd1024);
        widx = int'((a - BASE) >> 2) % 256;
        pend_cyc[k] = n + 1 + ew;
        pend_err[k] = !inr;
        pend_rd[k]  = !w;
        pend_dat[k] = inr ? mem_m[k][widx] : 32'h0;
        pend[k]     = 1'b1;
        drv_stb = 1'b0;
        rd = 32'h0; lat = -1;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            pend[k] = 1'b0;
            drv_cyc = 1'b0;
            if (abort_rst) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_ack", {29'd0, ack_v}, 32'd0);
                chk("rst_err", {29'd0, err_v}, 32'd0);
                chk("rst_dat", dat_v[k], 32'h0);
                rst = 1'b0;
                reseed();
            end
            repeat (ew + 2) @(posedge clk);
        end else begin
            seen = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (ack_v[k] || err_v[k]) begin
                    seen = 1'b1;
                    break;
                end
            end
            #1;
            pend[k] = 1'b0;
            drv_cyc = 1'b0;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL timeout dut%0d: no response within 40 cycles, expected at latency %0d", k, ew + 1);
            end else begin
                lat = cyc_cnt - n;
                rd  = dat_v[k];
                if (lat < WAITS[k] + 1 || lat > WAITS[k] + 4) begin
                    errors++;
                    $display("FAIL latency_window dut%0d: got %0d expected %0d..%0d", k, lat, WAITS[k] + 1, WAITS[k] + 4);
                end
                if (inr && w) begin
                    for (int i = 0; i < 4; i++)
                        if (s[i]) mem_m[k][widx][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd, a;
        int          lat, k, word;
        bit          w;
        reseed();
        for (int j = 0; j < 3; j++) pend[j] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("reset_ack", {31'd0, ack_v[j]}, 32'd0);
            chk("reset_err", {31'd0, err_v[j]}, 32'd0);
            chk("reset_dat", dat_v[j], 32'h0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic write/read with no wait states
        xfer(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 0, 1'b0, rd, lat);
        xfer(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("basic_read", rd, 32'hDEADBEEF);
`ifndef WB_RESP_RANDSTALL_EN
        chk("basic_latency", lat, 32'd1);
`endif

        // Byte lanes, then a sel=0 write that must change nothing
        xfer(0, 1'b1, BASE + 32'h20, 4'hF, 32'h11223344, 0, 1'b0, rd, lat);
        xfer(0, 1'b1, BASE + 32'h20, 4'b0101, 32'hAABBCCDD, 0, 1'b0, rd, lat);
        xfer(0, 1'b0, BASE + 32'h22, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("byte_lanes", rd, 32'h11BB33DD);
        xfer(0, 1'b1, BASE + 32'h20, 4'h0, 32'hFFFFFFFF, 0, 1'b0, rd, lat);
        xfer(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("sel_zero", rd, 32'h11BB33DD);

        // Wait states on the 3-cycle instance
        xfer(1, 1'b1, BASE + 32'h40, 4'hF, 32'h0BADC0DE, 0, 1'b0, rd, lat);
        xfer(1, 1'b0, BASE + 32'h40, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("wait3_read", rd, 32'h0BADC0DE);
`ifndef WB_RESP_RANDSTALL_EN
        chk("wait3_latency", lat, 32'd4);
`endif

        // Out of window above and below
        xfer(0, 1'b1, BASE, 4'hF, 32'h5A5A0000, 0, 1'b0, rd, lat);
        xfer(0, 1'b0, BASE + 32'd1024, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        xfer(0, 1'b1, BASE + 32'd1024, 4'hF, 32'h1, 0, 1'b0, rd, lat);
        xfer(0, 1'b1, BASE - 32'd4, 4'hF, 32'h2, 0, 1'b0, rd, lat);
        xfer(0, 1'b0, BASE, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("oor_word0", rd, 32'h5A5A0000);

        // Abort by cyc drop, then by reset, on the 4-cycle instance
        xfer(2, 1'b1, BASE + 32'h30, 4'hF, 32'h12345678, 0, 1'b0, rd, lat);
        xfer(2, 1'b1, BASE + 32'h30, 4'hF, 32'hCAFEF00D, 2, 1'b0, rd, lat);
        xfer(2, 1'b0, BASE + 32'h30, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("abort_cyc", rd, 32'h12345678);
        xfer(2, 1'b1, BASE + 32'h30, 4'hF, 32'hCAFEF00D, 2, 1'b1, rd, lat);
        xfer(2, 1'b0, BASE + 32'h30, 4'hF, 32'h0, 0, 1'b0, rd, lat);
        chk("abort_rst", rd, 32'h12345678);

        // Random traffic over a 16-word window of each instance
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 16; i++)
                xfer(j, 1'b1, BASE + 32'(i * 4), 4'hF, $urandom, 0, 1'b0, rd, lat);
        for (int i = 0; i < 1000; i++) begin
            k    = $urandom_range(0, 2);
            w    = 1'($urandom_range(0, 1));
            word = $urandom_range(0, 15);
            a    = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a + 32'd1024;
            xfer(k, w, a, 4'($urandom_range(0, 15)), $urandom, 0, 1'b0, rd, lat);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
